// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for the 5-stage RISC-V pipeline.
// Produces the pipeline-register write enables and bubble/flush controls
// for load-use, redirects, multi-cycle mul/div and data-memory waits.
// It also keeps a memory-wait watchdog and stall/flush statistics.
module pipeline_ctrl #(
    parameter int MD_LAT      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_ex,
    input  logic [4:0]  rdAddr_ex,
    input  logic [4:0]  rs1Addr_id,
    input  logic [4:0]  rs2Addr_id,
    input  logic        rs1Read_id,
    input  logic        rs2Read_id,
    input  logic        MulDiv_ex,
    input  logic        Redirect_ex,
    input  logic        MemReq_mem,
    input  logic        MemReady_mem,
    output logic        PCWrite,
    output logic        IF_IDWrite,
    output logic        ID_EXWrite,
    output logic        EX_MEMWrite,
    output logic        MEM_WBWrite,
    output logic        IF_IDFlush,
    output logic        ID_EXFlush,
    output logic        EX_MEMFlush,
    output logic        MulDivStart,
    output logic        MemTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
);

    localparam int CNT_W  = $clog2(MD_LAT);
    localparam int FCNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(MD_LAT - 2);
    localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [FCNT_W-1:0]  fcnt;
    logic [FCNT_W-1:0]  fcnt_next;
    logic               freeze;
    logic               load_use;
    logic               redirect_taken;

    assign freeze = MemReq_mem & ~MemReady_mem;

    assign load_use = MemRead_ex & (rdAddr_ex != 5'd0) &
                      ((rs1Read_id & (rs1Addr_id == rdAddr_ex)) |
                       (rs2Read_id & (rs2Addr_id == rdAddr_ex)));

    // Prioritised hazard decode: memory freeze, mul/div occupancy, redirect, load-use
    always_comb begin
        PCWrite        = 1'b1;
        IF_IDWrite     = 1'b1;
        ID_EXWrite     = 1'b1;
        EX_MEMWrite    = 1'b1;
        MEM_WBWrite    = 1'b1;
        IF_IDFlush     = 1'b0;
        ID_EXFlush     = 1'b0;
        EX_MEMFlush    = 1'b0;
        MulDivStart    = 1'b0;
        redirect_taken = 1'b0;
        state_next     = state;
        cnt_next       = cnt;

        if (reset) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMWrite = 1'b0;
            MEM_WBWrite = 1'b0;
        end else if (freeze) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMWrite = 1'b0;
            MEM_WBWrite = 1'b0;
            if ((state == MD_BUSY) && (cnt != '0)) begin
                cnt_next = cnt - 1'b1;
            end
        end else if (state == MD_BUSY) begin
            if (cnt != '0) begin
                PCWrite     = 1'b0;
                IF_IDWrite  = 1'b0;
                ID_EXWrite  = 1'b0;
                EX_MEMFlush = 1'b1;
                cnt_next    = cnt - 1'b1;
            end else begin
                state_next = RUN;
            end
        end else if (MulDiv_ex) begin
            MulDivStart = 1'b1;
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMFlush = 1'b1;
            cnt_next    = CNT_START;
            state_next  = MD_BUSY;
        end else if (Redirect_ex) begin
            IF_IDFlush     = 1'b1;
            ID_EXFlush     = 1'b1;
            redirect_taken = 1'b1;
        end else if (load_use) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            ID_EXFlush = 1'b1;
        end
    end

    // Consecutive-freeze counter that saturates at the timeout threshold
    always_comb begin
        fcnt_next = '0;
        if (freeze) begin
            fcnt_next = (fcnt == FCNT_MAX) ? fcnt : fcnt + 1'b1;
        end
    end

    // Controller state and mul/div occupancy counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Memory-wait watchdog with a sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt       <= '0;
            MemTimeout <= 1'b0;
        end else begin
            fcnt <= fcnt_next;
            if (fcnt_next == FCNT_MAX) begin
                MemTimeout <= 1'b1;
            end
        end
    end

    // Performance counters for stalled cycles and taken redirects
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (!PCWrite) begin
                StallCycles <= StallCycles + 32'd1;
            end
            if (redirect_taken) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl.
// Each stimulus cycle pushes its expected control vector; a negedge monitor
// pops and compares it while the combinational outputs are stable.
module tb_pipeline_ctrl;

    // Control vector order:
    // {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite,
    //  IF_IDFlush, ID_EXFlush, EX_MEMFlush, MulDivStart}
    localparam logic [8:0] C_RST   = 9'b00000_000_0;
    localparam logic [8:0] C_DEF   = 9'b11111_000_0;
    localparam logic [8:0] C_FRZ   = 9'b00000_000_0;
    localparam logic [8:0] C_MDGO  = 9'b00011_001_1;
    localparam logic [8:0] C_MDST  = 9'b00011_001_0;
    localparam logic [8:0] C_REDIR = 9'b11111_110_0;
    localparam logic [8:0] C_LU    = 9'b00111_010_0;

    typedef struct {
        string      tag;
        logic [8:0] ctrl;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        MemRead_ex;
    logic [4:0]  rdAddr_ex;
    logic [4:0]  rs1Addr_id;
    logic [4:0]  rs2Addr_id;
    logic        rs1Read_id;
    logic        rs2Read_id;
    logic        MulDiv_ex;
    logic        Redirect_ex;
    logic        MemReq_mem;
    logic        MemReady_mem;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        ID_EXWrite;
    logic        EX_MEMWrite;
    logic        MEM_WBWrite;
    logic        IF_IDFlush;
    logic        ID_EXFlush;
    logic        EX_MEMFlush;
    logic        MulDivStart;
    logic        MemTimeout;
    logic [31:0] StallCycles;
    logic [31:0] FlushCount;

    exp_t        expq[$];
    int          testCount = 0;
    int          failCount = 0;
    int          expStall  = 0;
    int          expFlush  = 0;

    pipeline_ctrl #(
        .MD_LAT      (4),
        .MEM_TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead_ex   (MemRead_ex),
        .rdAddr_ex    (rdAddr_ex),
        .rs1Addr_id   (rs1Addr_id),
        .rs2Addr_id   (rs2Addr_id),
        .rs1Read_id   (rs1Read_id),
        .rs2Read_id   (rs2Read_id),
        .MulDiv_ex    (MulDiv_ex),
        .Redirect_ex  (Redirect_ex),
        .MemReq_mem   (MemReq_mem),
        .MemReady_mem (MemReady_mem),
        .PCWrite      (PCWrite),
        .IF_IDWrite   (IF_IDWrite),
        .ID_EXWrite   (ID_EXWrite),
        .EX_MEMWrite  (EX_MEMWrite),
        .MEM_WBWrite  (MEM_WBWrite),
        .IF_IDFlush   (IF_IDFlush),
        .ID_EXFlush   (ID_EXFlush),
        .EX_MEMFlush  (EX_MEMFlush),
        .MulDivStart  (MulDivStart),
        .MemTimeout   (MemTimeout),
        .StallCycles  (StallCycles),
        .FlushCount   (FlushCount)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Queue the expected controls for the current input set and step one cycle
    task automatic applyStimulus(input string tag, input logic [8:0] ctrl);
        exp_t item;
        item.tag  = tag;
        item.ctrl = ctrl;
        expq.push_back(item);
        if (reset) begin
            expStall = 0;
            expFlush = 0;
        end else begin
            if (!ctrl[8]) expStall++;
            if (ctrl[3])  expFlush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        MemRead_ex   = 1'b0;
        rdAddr_ex    = 5'd0;
        rs1Addr_id   = 5'd0;
        rs2Addr_id   = 5'd0;
        rs1Read_id   = 1'b0;
        rs2Read_id   = 1'b0;
        MulDiv_ex    = 1'b0;
        Redirect_ex  = 1'b0;
        MemReq_mem   = 1'b0;
        MemReady_mem = 1'b0;
    endtask

    // Scoreboard monitor: compare outputs mid-cycle against the queued entry
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t item;
            item = expq.pop_front();
            checkOutput(item.tag,
                        {23'd0, PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite,
                         IF_IDFlush, ID_EXFlush, EX_MEMFlush, MulDivStart},
                        {23'd0, item.ctrl});
        end
    end

    initial begin
        reset = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;

        // Reset behaviour
        applyStimulus("reset0", C_RST);
        applyStimulus("reset1", C_RST);
        reset = 1'b0;
        checkOutput("rst_stall", StallCycles, 32'd0);
        checkOutput("rst_flush", FlushCount, 32'd0);
        checkOutput("rst_timeout", {31'd0, MemTimeout}, 32'd0);
        applyStimulus("idle", C_DEF);

        // Load-use on rs1, x0 destination, rs2 with and without read
        MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs1Addr_id = 5'd5; rs1Read_id = 1'b1;
        applyStimulus("lu_rs1", C_LU);
        checkOutput("lu_stall", StallCycles, 32'd1);
        rdAddr_ex = 5'd0; rs1Addr_id = 5'd0;
        applyStimulus("lu_x0", C_DEF);
        clearInputs();
        MemRead_ex = 1'b1; rdAddr_ex = 5'd7; rs2Addr_id = 5'd7; rs2Read_id = 1'b1;
        applyStimulus("lu_rs2", C_LU);
        rs2Read_id = 1'b0;
        applyStimulus("lu_rs2_noread", C_DEF);

        // Redirect overrides load-use
        rs2Read_id = 1'b1; Redirect_ex = 1'b1;
        applyStimulus("redir_lu", C_REDIR);
        clearInputs();
        checkOutput("redir_flushcnt", FlushCount, 32'd1);
        checkOutput("redir_stallcnt", StallCycles, 32'd2);

        // Back-to-back mul/div; redirect alongside the second start is ignored
        MulDiv_ex = 1'b1;
        applyStimulus("md_start", C_MDGO);
        applyStimulus("md_busy1", C_MDST);
        applyStimulus("md_busy2", C_MDST);
        applyStimulus("md_exit", C_DEF);
        checkOutput("md_stallcnt", StallCycles, 32'd5);
        Redirect_ex = 1'b1;
        applyStimulus("md2_start", C_MDGO);
        Redirect_ex = 1'b0;
        applyStimulus("md2_busy1", C_MDST);
        applyStimulus("md2_busy2", C_MDST);
        applyStimulus("md2_exit", C_DEF);
        clearInputs();
        checkOutput("md2_flushcnt", FlushCount, 32'd1);

        // Memory freeze in the middle of a mul/div
        MulDiv_ex = 1'b1;
        applyStimulus("mdf_start", C_MDGO);
        applyStimulus("mdf_busy1", C_MDST);
        MemReq_mem = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("mdf_freeze", C_FRZ);
        MemReq_mem = 1'b0;
        applyStimulus("mdf_exit", C_DEF);
        MulDiv_ex = 1'b0;
        applyStimulus("mdf_after", C_DEF);
        checkOutput("mdf_stallcnt", StallCycles, expStall);

        // Watchdog: 255 consecutive freeze cycles set the sticky flag
        MemReq_mem = 1'b1;
        for (int i = 0; i < 254; i++) applyStimulus("wd_freeze", C_FRZ);
        checkOutput("wd_before", {31'd0, MemTimeout}, 32'd0);
        applyStimulus("wd_freeze_last", C_FRZ);
        checkOutput("wd_set", {31'd0, MemTimeout}, 32'd1);
        MemReady_mem = 1'b1;
        applyStimulus("wd_ready", C_DEF);
        clearInputs();
        applyStimulus("wd_idle", C_DEF);
        checkOutput("wd_sticky", {31'd0, MemTimeout}, 32'd1);
        checkOutput("wd_stallcnt", StallCycles, expStall);
        checkOutput("wd_flushcnt", FlushCount, expFlush);

        // Reset aborts a mul/div with cnt=1
        MulDiv_ex = 1'b1;
        applyStimulus("rmd_start", C_MDGO);
        applyStimulus("rmd_busy1", C_MDST);
        reset = 1'b1;
        applyStimulus("rmd_reset", C_RST);
        reset = 1'b0;
        MulDiv_ex = 1'b0;
        checkOutput("rmd_stallcnt", StallCycles, 32'd0);
        checkOutput("rmd_flushcnt", FlushCount, 32'd0);
        checkOutput("rmd_timeout", {31'd0, MemTimeout}, 32'd0);
        applyStimulus("rmd_run", C_DEF);
        Redirect_ex = 1'b1;
        applyStimulus("post_redir", C_REDIR);
        clearInputs();
        checkOutput("post_flushcnt", FlushCount, 32'd1);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
